axis_tid_demux: RTL and testbench

Per-channel demultiplexer for the TID-tagged, interleaved sample stream produced by the multichannel FIR. It accepts one AXI-Stream whose `tid` selects the channel and routes each beat into a per-channel FIFO. Each FIFO drives an independent AXI-Stream master toward the per-channel consumers (DMA, DAC framers). Bad TIDs are dropped and counted, and per-channel backpressure is isolated by TID.

---
 rtl/dsp_axis_pkg.sv | 14 +
 rtl/axis_chan_fifo.sv | 41 ++++
 rtl/axis_tid_demux.sv | 74 +++++++
 tb/tb_axis_tid_demux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_axis_pkg.sv
// dsp_axis_pkg: shared stream defaults and beat layout for the FIR and the TID demux
package dsp_axis_pkg;
  localparam int N_CHANNELS_DEFAULT = 4;
  localparam int DATA_WIDTH_DEFAULT = 16;
  function automatic int tid_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int TID_WIDTH_DEFAULT = tid_width(N_CHANNELS_DEFAULT);
  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] data;
    logic                          last;
    logic [TID_WIDTH_DEFAULT-1:0]  id;
  } axis_beat_t;
endpackage

// File: rtl/axis_chan_fifo.sv
// axis_chan_fifo: first-word-fall-through FIFO with wrap-bit pointers and exposed level
module axis_chan_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int AW = LVL_W - 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr, rd_ptr;
  logic             wr_en, rd_en;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  // pointer update; reset flushes contents by realigning both pointers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_en ? wr_ptr + LVL_W'(1) : wr_ptr;
      rd_ptr <= rd_en ? rd_ptr + LVL_W'(1) : rd_ptr;
    end
  end
  // storage write, no reset needed since empty masks stale entries
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/axis_tid_demux.sv
// axis_tid_demux: routes a TID-tagged AXI-Stream into per-channel FWFT FIFOs, dropping bad TIDs
module axis_tid_demux
  import dsp_axis_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int TID_WIDTH  = tid_width(N_CHANNELS),
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [TID_WIDTH-1:0]             s_axis_tid,
  input  logic                             s_axis_tlast,
  output logic [N_CHANNELS-1:0]            m_axis_tvalid,
  input  logic [N_CHANNELS-1:0]            m_axis_tready,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [N_CHANNELS-1:0]            m_axis_tlast,
  output logic [N_CHANNELS*LVL_W-1:0]      fifo_level,
  output logic [N_CHANNELS-1:0]            frame_done,
  output logic                             bad_tid_err,
  output logic [15:0]                      drop_count,
  input  logic                             err_clear
);
  logic [N_CHANNELS-1:0] sel, full, empty, push, pop, last;
  logic                  bad_evt;
  assign bad_evt       = s_axis_tvalid && (32'(s_axis_tid) >= N_CHANNELS);
  assign s_axis_tready = ~|(sel & full);
  assign push          = {N_CHANNELS{s_axis_tvalid}} & sel & ~full;
  assign m_axis_tvalid = ~empty;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = last;
  genvar c;
  generate
    for (c = 0; c < N_CHANNELS; c++) begin : g_ch
      logic [DATA_WIDTH:0] head;
      assign sel[c] = s_axis_tid == TID_WIDTH'(c);
      assign last[c] = head[DATA_WIDTH];
      assign m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
      axis_chan_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_WIDTH + 1),
        .LVL_W(LVL_W)
      ) u_fifo (
        .aclk   (aclk),
        .aresetn(aresetn),
        .push   (push[c]),
        .din    ({s_axis_tlast, s_axis_tdata}),
        .pop    (pop[c]),
        .dout   (head),
        .full   (full[c]),
        .empty  (empty[c]),
        .level  (fifo_level[c*LVL_W +: LVL_W])
      );
    end
  endgenerate
  // frame end pulse, one cycle after a tlast beat leaves its channel
  always_ff @(posedge aclk) begin
    frame_done <= !aresetn ? '0 : pop & last;
  end
  // sticky bad-TID flag and saturating drop counter; clear wins over a same-cycle drop
  always_ff @(posedge aclk) begin
    if (!aresetn || err_clear) begin
      bad_tid_err <= 1'b0;
      drop_count  <= '0;
    end else if (bad_evt) begin
      bad_tid_err <= 1'b1;
      drop_count  <= drop_count + 16'(drop_count != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_axis_tid_demux.sv
// tb_axis_tid_demux: directed scoreboard bench for the TID demux (4-channel and 3-channel instances)
module tb_axis_tid_demux;
  logic        clk = 0;
  logic        aresetn = 0;
  logic        s_v = 0, s_l = 0, s_rdy;
  logic [15:0] s_d = '0;
  logic [1:0]  s_id = '0;
  logic [3:0]  m_r = 4'hF, v4, t4, fd4;
  logic [63:0] d4;
  logic [15:0] l4;
  logic        err4;
  logic [15:0] drop4;
  logic        t_v = 0, t_l = 0, t_clr = 0, t_rdy;
  logic [15:0] t_d = '0;
  logic [1:0]  t_id = '0;
  logic [2:0]  m_r3 = 3'b111, v3, t3, fd3;
  logic [47:0] d3;
  logic [11:0] l3;
  logic        err3;
  logic [15:0] drop3;
  int          checks = 0, errors = 0;
  int          fd_cnt [4];
  logic        mon_en = 0;
  logic [3:0]  fd_pred = '0;
  logic [16:0] sb [4][$];
  logic        acc;
  int          base;

  always #5 clk = ~clk;

  axis_tid_demux #(.N_CHANNELS(4), .DATA_WIDTH(16), .FIFO_DEPTH(8)) u4 (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tvalid(s_v), .s_axis_tready(s_rdy), .s_axis_tdata(s_d), .s_axis_tid(s_id), .s_axis_tlast(s_l),
    .m_axis_tvalid(v4), .m_axis_tready(m_r), .m_axis_tdata(d4), .m_axis_tlast(t4),
    .fifo_level(l4), .frame_done(fd4), .bad_tid_err(err4), .drop_count(drop4), .err_clear(1'b0)
  );

  axis_tid_demux #(.N_CHANNELS(3), .DATA_WIDTH(16), .FIFO_DEPTH(8)) u3 (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tvalid(t_v), .s_axis_tready(t_rdy), .s_axis_tdata(t_d), .s_axis_tid(t_id), .s_axis_tlast(t_l),
    .m_axis_tvalid(v3), .m_axis_tready(m_r3), .m_axis_tdata(d3), .m_axis_tlast(t3),
    .fifo_level(l3), .frame_done(fd3), .bad_tid_err(err3), .drop_count(drop3), .err_clear(t_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lvl(input int c);
    return l4[c*4 +: 4];
  endfunction

  function automatic int pending();
    return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
  endfunction

  task automatic try_beat(input int tid, input logic [15:0] d, input logic l, output logic ok);
    s_v = 1; s_id = tid[1:0]; s_d = d; s_l = l;
    @(negedge clk);
    ok = s_rdy;
    if (ok) sb[tid].push_back({l, d});
    @(posedge clk); #1;
    s_v = 0;
  endtask

  task automatic send(input int tid, input logic [15:0] d, input logic l);
    logic ok = 0;
    for (int i = 0; i < 50 && !ok; i++) try_beat(tid, d, l, ok);
    check("send_accept", {31'b0, ok}, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && pending() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", pending(), 0);
  endtask

  // output monitor: checks pops against the scoreboard and predicts frame_done
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (fd4 === fd_pred) else begin
        errors++;
        $error("FAIL frame_done: observed %b expected %b", fd4, fd_pred);
      end
      for (int c = 0; c < 4; c++) if (fd4[c]) fd_cnt[c]++;
      checks++;
      assert (v3 === 3'b000) else begin
        errors++;
        $error("FAIL n3_no_output: observed %b expected 000", v3);
      end
      fd_pred = '0;
      if (aresetn) begin
        for (int c = 0; c < 4; c++) begin
          if (v4[c] && m_r[c]) begin
            logic [16:0] obs_w, exp_w;
            obs_w = {t4[c], d4[c*16 +: 16]};
            checks++;
            assert (sb[c].size() != 0) else begin
              errors++;
              $error("FAIL ch%0d_unexpected: observed %h expected none", c, obs_w);
            end
            if (sb[c].size() != 0) begin
              exp_w = sb[c].pop_front();
              checks++;
              assert (obs_w === exp_w) else begin
                errors++;
                $error("FAIL ch%0d_data: observed %h expected %h", c, obs_w, exp_w);
              end
              fd_pred[c] = exp_w[16];
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 4; c++) fd_cnt[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1;
    check("rst_level", {16'b0, l4}, 0);
    check("rst_valid", {28'b0, v4}, 0);
    check("rst_ready", {31'b0, s_rdy}, 1);
    check("rst_fdone", {28'b0, fd4}, 0);
    check("rst_err", {31'b0, err3}, 0);
    check("rst_drop", {16'b0, drop3}, 0);
    mon_en = 1;

    for (int i = 0; i < 4; i++) begin
      try_beat(i, 16'(16'h0100 + i), 1'b0, acc);
      check("t1_accept", {31'b0, acc}, 1);
      check("t1_valid_next", {31'b0, v4[i]}, 1);
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("t1_levels_zero", {16'b0, l4}, 0);

    m_r = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      try_beat(2, 16'(16'h0200 + i), 1'b0, acc);
      check("t2_fill_accept", {31'b0, acc}, 1);
    end
    check("t2_level_full", {28'b0, lvl(2)}, 8);
    try_beat(2, 16'h0208, 1'b0, acc);
    check("t2_ninth_stall", {31'b0, acc}, 0);
    try_beat(0, 16'h00A0, 1'b0, acc);
    check("t2_other_tid", {31'b0, acc}, 1);
    m_r = 4'hF;
    send(2, 16'h0208, 1'b0);
    drain();
    check("t2_level_after", {28'b0, lvl(2)}, 0);

    base = fd_cnt[1];
    for (int i = 0; i < 4; i++) send(1, 16'(16'h0300 + i), i == 3);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("t4_frame_done_once", fd_cnt[1] - base, 1);

    t_v = 1; t_id = 2'd3; t_d = 16'hDEAD;
    @(negedge clk);
    check("t3_ready_bad1", {31'b0, t_rdy}, 1);
    @(posedge clk); #1;
    check("t3_drop_one", {16'b0, drop3}, 1);
    @(negedge clk);
    check("t3_ready_bad2", {31'b0, t_rdy}, 1);
    @(posedge clk); #1;
    t_v = 0;
    check("t3_err", {31'b0, err3}, 1);
    check("t3_drop_two", {16'b0, drop3}, 2);
    check("t3_level_zero", {20'b0, l3}, 0);
    t_clr = 1;
    @(posedge clk); #1;
    t_clr = 0;
    check("t3_clr_err", {31'b0, err3}, 0);
    check("t3_clr_drop", {16'b0, drop3}, 0);
    t_v = 1; t_clr = 1;
    @(posedge clk); #1;
    t_v = 0; t_clr = 0;
    check("t3_clr_prio_err", {31'b0, err3}, 0);
    check("t3_clr_prio_drop", {16'b0, drop3}, 0);

    m_r = 4'b1110;
    for (int i = 0; i < 3; i++) send(0, 16'(16'h0500 + i), 1'b0);
    check("t5_level3", {28'b0, lvl(0)}, 3);
    m_r = 4'hF;
    for (int i = 0; i < 20; i++) begin
      try_beat(0, 16'(16'h0510 + i), 1'b0, acc);
      check("t5_pushpop_accept", {31'b0, acc}, 1);
      check("t5_level_hold", {28'b0, lvl(0)}, 3);
    end
    drain();

    m_r = 4'b1110;
    for (int i = 0; i < 5; i++) send(0, 16'(16'h0600 + i), i == 4);
    check("t6_level5", {28'b0, lvl(0)}, 5);
    aresetn = 0;
    @(posedge clk); #1;
    aresetn = 1;
    sb[0].delete();
    check("t6_levels_zero", {16'b0, l4}, 0);
    check("t6_valid_zero", {28'b0, v4}, 0);
    check("t6_ready", {31'b0, s_rdy}, 1);
    m_r = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("t6_stays_empty", {28'b0, v4}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
